// File: rtl/uart_msg_ctl_if.sv
// ---------------------------------------------------------------------------
// uart_msg_ctl_if
// Bundles the byte-level signals between uart_msg_ctl and its neighbours
// (UART RX core, UART TX core, control/status).
//   mode_sw  : mode select from a switch (asynchronous), 0 = echo, 1 = send
//   rx_data  : byte from UART RX, qualified by the one-cycle rx_valid strobe
//   tx_data  : byte to UART TX, qualified by tx_valid, consumed on tx_ready
//   ovf_clr  : clears the sticky overflow flag
//   ovf      : sticky echo-FIFO overflow flag
//   busy     : message in flight or echo bytes still pending
// The slave modport is the uart_msg_ctl side; master is the environment side.
// ---------------------------------------------------------------------------
interface uart_msg_ctl_if #(
  parameter int DATA_W = 8
);
  logic              mode_sw;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              ovf_clr;
  logic              ovf;
  logic              busy;

  modport master (
    output mode_sw, rx_data, rx_valid, tx_ready, ovf_clr,
    input  tx_data, tx_valid, ovf, busy
  );

  modport slave (
    input  mode_sw, rx_data, rx_valid, tx_ready, ovf_clr,
    output tx_data, tx_valid, ovf, busy
  );
endinterface

// File: rtl/uart_msg_ctl.sv
// ---------------------------------------------------------------------------
// uart_msg_ctl
// Mode-selectable byte source for the UART TX path.
//   Echo mode: received bytes are buffered in a FIFO and replayed to TX.
//   Send mode: a fixed message is transmitted every PERIOD cycles.
// Ports:
//   clk  : clock, all logic on the rising edge
//   rst  : synchronous reset, active-high
//   bus  : uart_msg_ctl_if.slave (mode_sw, rx_data/rx_valid, tx_data/tx_valid/
//          tx_ready, ovf_clr, ovf, busy)
// Build option:
//   ECHO_UPCASE_EN : when defined, echoed bytes 'a'..'z' are emitted as
//                    'A'..'Z'. The FIFO keeps raw bytes; the mapping is applied
//                    when a byte is loaded into the TX register. Message bytes
//                    are never mapped.
// ---------------------------------------------------------------------------
module uart_msg_ctl #(
  parameter int                   DATA_W     = 8,
  parameter int                   FIFO_DEPTH = 16,
  parameter int                   PERIOD     = 100000000,
  parameter int                   MSG_LEN    = 15,
  parameter logic [8*MSG_LEN-1:0] MSG        = "Hello, world!\r\n"
) (
  input logic           clk,
  input logic           rst,
  uart_msg_ctl_if.slave bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(PERIOD + 1);
  localparam int IW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;

  localparam logic [1:0] S_ECHO = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_SEND = 2'd2;

`ifdef ECHO_UPCASE_EN
  localparam logic [DATA_W-1:0] LC_A     = DATA_W'(8'h61);
  localparam logic [DATA_W-1:0] LC_Z     = DATA_W'(8'h7A);
  localparam logic [DATA_W-1:0] CASE_OFS = DATA_W'(8'h20);
`endif

  // Character i of the message; character 0 sits in the most significant byte.
  function automatic logic [DATA_W-1:0] msg_char(input int i);
    logic [7:0] c;
    c = MSG[8*(MSG_LEN-1-i) +: 8];
    return DATA_W'(c);
  endfunction

  function automatic logic [DATA_W-1:0] echo_map(input logic [DATA_W-1:0] b);
`ifdef ECHO_UPCASE_EN
    if (b >= LC_A && b <= LC_Z) return b - CASE_OFS;
    return b;
`else
    return b;
`endif
  endfunction

  logic              r_mode_meta;
  logic              r_mode_s;
  logic [1:0]        r_state;
  logic [PW-1:0]     r_wr;
  logic [PW-1:0]     r_rd;
  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [CW-1:0]     r_cnt;
  logic [IW-1:0]     r_idx;
  logic [DATA_W-1:0] r_tx_data;
  logic              r_tx_valid;
  logic              r_ovf;

  logic              w_full;
  logic              w_pop;
  logic              w_push;
  logic              w_ovf_set;
  logic [PW-1:0]     w_rd_nxt;
  logic              w_stored;
  logic              w_echo_avail;
  logic [DATA_W-1:0] w_echo_byte;
  logic              w_last;
  logic              w_cnt_done;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign w_full    = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  // The presented echo byte stays in the FIFO until TX accepts it.
  assign w_pop     = (r_state == S_ECHO) && r_tx_valid && bus.tx_ready;
  // A pop in the same cycle frees the slot a push into a full FIFO needs.
  assign w_push    = bus.rx_valid && (!w_full || w_pop);
  assign w_ovf_set = bus.rx_valid && w_full && !w_pop;
  assign w_rd_nxt  = w_pop ? r_rd + PW'(1) : r_rd;

  // Next echo byte: from storage if anything remains after this cycle's pop,
  // otherwise forwarded from the incoming byte being pushed this cycle.
  assign w_stored     = (r_wr != w_rd_nxt);
  assign w_echo_avail = w_stored || w_push;
  assign w_echo_byte  = w_stored ? r_mem[w_rd_nxt[AW-1:0]] : bus.rx_data;

  assign w_last     = (r_idx == IW'(MSG_LEN - 1));
  assign w_cnt_done = (r_cnt == CW'(PERIOD - 1));

  // Mode switch synchroniser
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode_meta <= 1'b0;
      r_mode_s    <= 1'b0;
    end else begin
      r_mode_meta <= bus.mode_sw;
      r_mode_s    <= r_mode_meta;
    end
  end

  // Echo FIFO storage
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr[AW-1:0]] <= bus.rx_data;
  end

  // Echo FIFO pointers and overflow flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (w_push) r_wr <= r_wr + PW'(1);
      r_rd <= w_rd_nxt;
      // A new overflow wins over a simultaneous clear.
      if (w_ovf_set)        r_ovf <= 1'b1;
      else if (bus.ovf_clr) r_ovf <= 1'b0;
    end
  end

  // Mode FSM and TX output register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_ECHO;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_tx_valid <= 1'b0;
      r_tx_data  <= '0;
    end else begin
      case (r_state)
        S_ECHO: begin
          // The mode is only re-examined while no byte is on offer.
          if (!r_tx_valid && r_mode_s) begin
            r_state <= S_WAIT;
            r_cnt   <= '0;
          end else if (!r_tx_valid || w_pop) begin
            r_tx_valid <= w_echo_avail;
            if (w_echo_avail) r_tx_data <= echo_map(w_echo_byte);
          end
        end
        S_WAIT: begin
          if (!r_mode_s) begin
            r_state <= S_ECHO;
          end else if (w_cnt_done) begin
            r_state    <= S_SEND;
            r_idx      <= '0;
            r_tx_valid <= 1'b1;
            r_tx_data  <= msg_char(0);
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_SEND: begin
          // The message always runs to completion regardless of the mode.
          if (bus.tx_ready) begin
            if (w_last) begin
              r_state    <= S_WAIT;
              r_cnt      <= '0;
              r_tx_valid <= 1'b0;
            end else begin
              r_idx     <= r_idx + IW'(1);
              r_tx_data <= msg_char(int'(r_idx) + 1);
            end
          end
        end
        default: begin
          r_state    <= S_ECHO;
          r_tx_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.tx_data  = r_tx_data;
  assign bus.tx_valid = r_tx_valid;
  assign bus.ovf      = r_ovf;
  assign bus.busy     = (r_state == S_SEND) || (r_wr != r_rd);

endmodule

// File: tb/tb_uart_msg_ctl.sv
// ---------------------------------------------------------------------------
// tb_uart_msg_ctl
// Directed and randomized stimulus for uart_msg_ctl with a queue-based
// reference model of the echo path and fixed timing expectations for the
// periodic message (FIFO_DEPTH=4, PERIOD=20, MSG="AB\n").
// ---------------------------------------------------------------------------
module tb_uart_msg_ctl;

  localparam int          DATA_W     = 8;
  localparam int          FIFO_DEPTH = 4;
  localparam int          PERIOD     = 20;
  localparam int          MSG_LEN    = 3;
  localparam logic [23:0] MSG        = "AB\n";

  logic clk = 1'b0;
  logic rst;

  uart_msg_ctl_if #(.DATA_W(DATA_W)) bus ();

  uart_msg_ctl #(
    .DATA_W    (DATA_W),
    .FIFO_DEPTH(FIFO_DEPTH),
    .PERIOD    (PERIOD),
    .MSG_LEN   (MSG_LEN),
    .MSG       (MSG)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int         n_vec = 0;
  int         n_err = 0;
  bit         echo_on = 1'b0;
  bit         m_ovf = 1'b0;
  logic [7:0] mq[$];
  logic [7:0] exp_msg [3] = '{8'h41, 8'h42, 8'h0A};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_map(input logic [7:0] b);
`ifdef ECHO_UPCASE_EN
    if (b >= 8'h61 && b <= 8'h7A) return b - 8'h20;
`endif
    return b;
  endfunction

  // One clock: update the model from the inputs/outputs seen before the edge,
  // then compare the DUT state after the edge (sampled on the falling edge).
  task automatic tick();
    bit         acc, hold, ovf_now;
    logic [7:0] pd;
    acc     = bus.tx_valid && bus.tx_ready;
    hold    = bus.tx_valid && !bus.tx_ready;
    pd      = bus.tx_data;
    ovf_now = 1'b0;
    if (echo_on && acc) begin
      check("echo_pending", 32'(mq.size() != 0), 32'd1);
      if (mq.size() != 0) begin
        check("echo_data", 32'(bus.tx_data), 32'(exp_map(mq[0])));
        void'(mq.pop_front());
      end
    end
    if (bus.rx_valid) begin
      if (mq.size() < FIFO_DEPTH) mq.push_back(bus.rx_data);
      else ovf_now = 1'b1;
    end
    if (ovf_now) m_ovf = 1'b1;
    else if (bus.ovf_clr) m_ovf = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("ovf", 32'(bus.ovf), 32'(m_ovf));
    if (hold) begin
      check("hold_valid", 32'(bus.tx_valid), 32'd1);
      check("hold_data", 32'(bus.tx_data), 32'(pd));
    end
    if (echo_on) begin
      check("echo_valid", 32'(bus.tx_valid), 32'(mq.size() != 0));
      check("echo_busy", 32'(bus.busy), 32'(mq.size() != 0));
    end
  endtask

  task automatic drain();
    int n;
    bus.rx_valid = 1'b0;
    bus.tx_ready = 1'b1;
    n = 0;
    while (mq.size() != 0 && n < 40) begin
      tick();
      n++;
    end
    check("drain_done", 32'(mq.size()), 32'd0);
  endtask

  initial begin
    int   n;
    bit   acc;
    logic [7:0] b;

    rst          = 1'b1;
    bus.mode_sw  = 1'b0;
    bus.rx_data  = '0;
    bus.rx_valid = 1'b0;
    bus.tx_ready = 1'b0;
    bus.ovf_clr  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
    check("rst_tx_data", 32'(bus.tx_data), 32'd0);
    check("rst_ovf", 32'(bus.ovf), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    rst = 1'b0;

    // Single echoed byte with TX always ready
    echo_on      = 1'b1;
    bus.tx_ready = 1'b1;
    repeat (10) tick();
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'h41;
    tick();
    bus.rx_valid = 1'b0;
    check("t1_valid", 32'(bus.tx_valid), 32'd1);
    check("t1_data", 32'(bus.tx_data), 32'h41);
    tick();
    check("t1_done", 32'(bus.tx_valid), 32'd0);

    // Overflow: five bytes into a four-entry FIFO with TX stalled
    bus.tx_ready = 1'b0;
    for (int v = 1; v <= 5; v++) begin
      bus.rx_valid = 1'b1;
      bus.rx_data  = 8'(v);
      tick();
    end
    bus.rx_valid = 1'b0;
    check("t2_ovf_set", 32'(bus.ovf), 32'd1);
    check("t2_head", 32'(bus.tx_data), 32'h01);
    drain();
    check("t2_ovf_sticky", 32'(bus.ovf), 32'd1);
    bus.ovf_clr = 1'b1;
    tick();
    bus.ovf_clr = 1'b0;
    check("t2_ovf_clr", 32'(bus.ovf), 32'd0);

    // Full FIFO: push and pop in the same cycle is not an overflow
    bus.tx_ready = 1'b0;
    for (int v = 0; v < FIFO_DEPTH; v++) begin
      bus.rx_valid = 1'b1;
      bus.rx_data  = 8'($urandom_range(0, 255));
      tick();
    end
    bus.tx_ready = 1'b1;
    bus.rx_data  = 8'($urandom_range(0, 255));
    tick();
    check("t3_no_ovf", 32'(bus.ovf), 32'd0);
    bus.tx_ready = 1'b0;
    bus.rx_data  = 8'hEE;
    tick();
    check("t3_still_full", 32'(bus.ovf), 32'd1);
    bus.ovf_clr = 1'b1;
    tick();
    check("t3_ovf_beats_clr", 32'(bus.ovf), 32'd1);
    bus.rx_valid = 1'b0;
    tick();
    bus.ovf_clr = 1'b0;
    check("t3_ovf_clr", 32'(bus.ovf), 32'd0);
    drain();

    // Case mapping of echoed bytes
    bus.tx_ready = 1'b1;
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'h61;
    tick();
    bus.rx_data  = 8'h7B;
`ifdef ECHO_UPCASE_EN
    check("t6_lower_a", 32'(bus.tx_data), 32'h41);
`else
    check("t6_lower_a", 32'(bus.tx_data), 32'h61);
`endif
    tick();
    bus.rx_valid = 1'b0;
    check("t6_brace", 32'(bus.tx_data), 32'h7B);
    drain();

    // Randomized echo traffic
    for (int k = 0; k < 400; k++) begin
      bus.rx_valid = ($urandom_range(0, 2) == 0);
      bus.rx_data  = 8'($urandom_range(0, 255));
      bus.tx_ready = 1'($urandom_range(0, 1));
      bus.ovf_clr  = ($urandom_range(0, 15) == 0);
      tick();
    end
    bus.ovf_clr = 1'b1;
    drain();
    tick();
    bus.ovf_clr = 1'b0;

    // Send mode: first message start latency, content, and repeat period
    echo_on      = 1'b0;
    bus.tx_ready = 1'b1;
    bus.mode_sw  = 1'b1;
    n = 0;
    while (!bus.tx_valid && n < 200) begin
      tick();
      n++;
    end
    check("t4_start_latency", 32'(n), 32'(3 + PERIOD));
    for (int i = 0; i < MSG_LEN; i++) begin
      check("t4_valid", 32'(bus.tx_valid), 32'd1);
      check("t4_char", 32'(bus.tx_data), 32'(exp_msg[i]));
      check("t4_busy", 32'(bus.busy), 32'd1);
      tick();
    end
    check("t4_gap_valid", 32'(bus.tx_valid), 32'd0);
    n = 0;
    while (!bus.tx_valid && n < 200) begin
      tick();
      n++;
    end
    check("t4_repeat_gap", 32'(n), 32'(PERIOD));

    // Mode dropped mid-message with irregular TX readiness; a byte arrives
    // and must be held until echo resumes
    bus.mode_sw = 1'b0;
    for (int i = 0; i < MSG_LEN; i++) begin
      n = 0;
      do begin
        bus.tx_ready = 1'($urandom_range(0, 1));
        bus.rx_valid = (i == 0 && n == 0);
        bus.rx_data  = 8'h7A;
        check("t5_valid", 32'(bus.tx_valid), 32'd1);
        check("t5_char", 32'(bus.tx_data), 32'(exp_msg[i]));
        acc = bus.tx_ready;
        tick();
        n++;
      end while (!acc && n < 60);
    end
    bus.rx_valid = 1'b0;
    bus.tx_ready = 1'b0;
    n = 0;
    while (!bus.tx_valid && n < 20) begin
      tick();
      n++;
    end
    b = exp_map(8'h7A);
    check("t5_resume_valid", 32'(bus.tx_valid), 32'd1);
    check("t5_held_byte", 32'(bus.tx_data), 32'(b));
    echo_on      = 1'b1;
    bus.tx_ready = 1'b1;
    tick();
    check("t5_idle_busy", 32'(bus.busy), 32'd0);

    // Echo still operational after returning from send mode
    for (int k = 0; k < 60; k++) begin
      bus.rx_valid = ($urandom_range(0, 1) == 0);
      bus.rx_data  = 8'($urandom_range(0, 255));
      bus.tx_ready = 1'($urandom_range(0, 1));
      tick();
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
